uart_tx_engine: RTL and testbench

// Serialises one byte per frame onto the UART line: start bit, DBIT data bits LSB-first,

---
 rtl/uart_tx_engine.sv | 152 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine
//  Description : UART transmit serialiser. Sends start bit, DBIT data bits
//                LSB-first, optional parity bit and stop period, paced by a
//                16x oversampling baud tick. The done pulse pops the feeding
//                FIFO, so it is combinational on the final stop tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_done_tick,
  output logic            tx_busy,
  output logic            tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [4:0] c_BIT_LAST  = 5'd15;
  localparam logic [4:0] c_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] c_DBIT_LAST = 3'(DBIT - 1);
  localparam logic       c_ODD       = (PARITY_ODD != 0);
  localparam logic       c_PAR_EN    = (PARITY_EN != 0);

  state_t            state_q, state_d;
  logic [4:0]        s_cnt_q, s_cnt_d;
  logic [2:0]        n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]   shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_d;

  // State, counters, shift register and registered line output.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      s_cnt_q <= 5'd0;
      n_cnt_q <= 3'd0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; the line level is derived from the next state so that
  // tx is registered yet changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        // A coincident tick is deliberately not counted here.
        if (tx_start) begin
          shreg_d = din;
          s_cnt_d = 5'd0;
          n_cnt_d = 3'd0;
          par_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == c_BIT_LAST) begin
            s_cnt_d = 5'd0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == c_BIT_LAST) begin
            s_cnt_d = 5'd0;
            par_d   = par_q ^ shreg_q[0];
            shreg_d = shreg_q >> 1;
            if (n_cnt_q == c_DBIT_LAST) begin
              state_d = c_PAR_EN ? PARITY : STOP;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == c_BIT_LAST) begin
            s_cnt_d = 5'd0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == c_STOP_LAST) begin
            s_cnt_d = 5'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d ^ c_ODD;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_done_tick = done_d;
  assign tx_busy      = (state_q != IDLE);
  assign tx           = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_engine
//  Description : Directed self-checking bench for uart_tx_engine. Four
//                instances cover default, even parity, odd parity and 2 stop
//                bits. Line traces are captured per clock relative to the
//                accepting edge A; index n holds the cycle after edge A+n-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       Reset;
  logic       s_tick = 1'b0;
  logic [1:0] tcnt = 2'd0;
  logic       start_a [4];
  logic [7:0] din_a   [4];
  logic       tx_a    [4];
  logic       busy_a  [4];
  logic       done_a  [4];

  logic tr_tx   [0:1400];
  logic tr_busy [0:1400];
  logic tr_done [0:1400];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Baud tick: one clock high out of every four.
  always @(posedge clk) begin
    tcnt   <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd3);
  end

  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .tx_start(start_a[0]), .din(din_a[0]),
    .tx_done_tick(done_a[0]), .tx_busy(busy_a[0]), .tx(tx_a[0]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .tx_start(start_a[1]), .din(din_a[1]),
    .tx_done_tick(done_a[1]), .tx_busy(busy_a[1]), .tx(tx_a[1]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .tx_start(start_a[2]), .din(din_a[2]),
    .tx_done_tick(done_a[2]), .tx_busy(busy_a[2]), .tx(tx_a[2]));
  uart_tx_engine #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .tx_start(start_a[3]), .din(din_a[3]),
    .tx_done_tick(done_a[3]), .tx_busy(busy_a[3]), .tx(tx_a[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise tx_start during a tick cycle so the accepting edge coincides with a tick.
  task automatic launch(input int idx, input logic [7:0] d);
    bit found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_tick) begin
        found = 1;
        break;
      end
    end
    chk("tick_align", 32'(found), 32'd1);
    chk("idle_line", 32'(tx_a[idx]), 32'd1);
    din_a[idx]   = d;
    start_a[idx] = 1'b1;
  endtask

  // mode 0: single pulse; 1: toggle start and scramble din mid-frame;
  // 2: hold start, present next byte after the done edge; 3: reset mid-frame.
  task automatic capture(input int idx, input int n_cyc, input int mode);
    bit seen = 0;
    int seen_n = 0;
    for (int n = 1; n <= n_cyc; n++) begin
      @(negedge clk);
      tr_tx[n]   = tx_a[idx];
      tr_busy[n] = busy_a[idx];
      tr_done[n] = done_a[idx];
      case (mode)
        0: if (n == 1) start_a[idx] = 1'b0;
        1: begin
          start_a[idx] = (n < 600) ? ((n % 7) < 3) : 1'b0;
          if (n < 600) din_a[idx] = 8'(n);
        end
        2: begin
          if (tr_done[n] && !seen) begin
            seen = 1;
            seen_n = n;
          end
          if (seen && n == seen_n + 1) din_a[idx] = 8'hF0;
          if (n == 1270) start_a[idx] = 1'b0;
        end
        3: begin
          if (n == 1) start_a[idx] = 1'b0;
          if (n == 290) begin
            Reset = 1'b1;
            #1;
            chk("rst_async_tx", 32'(tx_a[idx]), 32'd1);
            chk("rst_async_busy", 32'(busy_a[idx]), 32'd0);
            chk("rst_async_done", 32'(done_a[idx]), 32'd0);
          end
          if (n == 292) Reset = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // Checks one captured frame of nb 64-clk bits after the start bit.
  task automatic check_frame(input string tag, input logic [15:0] val, input int nb,
                             input int done_idx, input int n_cyc);
    int cnt = 0;
    int first = -1;
    chk({tag, "_low_latency"}, 32'(tr_tx[1]), 32'd0);
    chk({tag, "_start_mid"}, 32'(tr_tx[32]), 32'd0);
    chk({tag, "_start_end"}, 32'(tr_tx[64]), 32'd0);
    chk({tag, "_bit0_begin"}, 32'(tr_tx[65]), 32'(val[0]));
    for (int k = 0; k < nb; k++)
      chk($sformatf("%s_bit%0d", tag, k), 32'(tr_tx[64 * (k + 1) + 32]), 32'(val[k]));
    chk({tag, "_busy_mid"}, 32'(tr_busy[320]), 32'd1);
    chk({tag, "_stop_mid"}, 32'(tr_tx[done_idx - 8]), 32'd1);
    for (int n = 1; n <= n_cyc; n++) begin
      if (tr_done[n]) begin
        cnt++;
        if (first < 0) first = n;
      end
    end
    chk({tag, "_done_count"}, 32'(cnt), 32'd1);
    chk({tag, "_done_at"}, 32'(first), 32'(done_idx));
    chk({tag, "_idle_tx"}, 32'(tr_tx[done_idx + 1]), 32'd1);
    chk({tag, "_idle_busy"}, 32'(tr_busy[done_idx + 1]), 32'd0);
  endtask

  initial begin
    int cnt;
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_a[i] = 1'b0;
      din_a[i]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_tx%0d", i), 32'(tx_a[i]), 32'd1);
      chk($sformatf("reset_busy%0d", i), 32'(busy_a[i]), 32'd0);
      chk($sformatf("reset_done%0d", i), 32'(done_a[i]), 32'd0);
    end
    Reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_hold_tx", 32'(tx_a[0]), 32'd1);
    chk("idle_hold_busy", 32'(busy_a[0]), 32'd0);

    // 0x55, no parity, one stop bit: done at 640 clk.
    launch(0, 8'h55);
    capture(0, 700, 0);
    check_frame("f55", 16'h0055, 8, 640, 700);

    // 0xA3 even parity -> parity bit 0; odd parity -> parity bit 1.
    launch(1, 8'hA3);
    capture(1, 770, 0);
    check_frame("pe", 16'h00A3, 9, 704, 770);
    launch(2, 8'hA3);
    capture(2, 770, 0);
    check_frame("po", 16'h01A3, 9, 704, 770);

    // Two stop bits: 128 clk of stop-high, done on the final tick.
    launch(3, 8'h55);
    capture(3, 770, 0);
    check_frame("sb32", 16'h0055, 8, 704, 770);
    chk("sb32_stop_early", 32'(tr_tx[580]), 32'd1);
    chk("sb32_stop_late", 32'(tr_busy[700]), 32'd1);

    // Back-to-back 0x0F then 0xF0 with tx_start held high.
    launch(0, 8'h0F);
    capture(0, 1300, 2);
    chk("b2b_f1_bit0", 32'(tr_tx[96]), 32'd1);
    chk("b2b_f1_bit7", 32'(tr_tx[544]), 32'd0);
    chk("b2b_done1", 32'(tr_done[640]), 32'd1);
    chk("b2b_stop_last", 32'(tr_tx[640]), 32'd1);
    chk("b2b_gap_high", 32'(tr_tx[641]), 32'd1);
    chk("b2b_gap_idle", 32'(tr_busy[641]), 32'd0);
    chk("b2b_f2_start", 32'(tr_tx[642]), 32'd0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("b2b_f2_bit%0d", k), 32'(tr_tx[640 + 64 * (k + 1) + 32]), 32'(k >= 4));
    chk("b2b_done2", 32'(tr_done[1280]), 32'd1);
    cnt = 0;
    for (int n = 1; n <= 1300; n++) if (tr_done[n]) cnt++;
    chk("b2b_done_count", 32'(cnt), 32'd2);

    // Reset during data bit 3 of 0x81 aborts the frame without a done pulse.
    launch(0, 8'h81);
    capture(0, 800, 3);
    chk("rst_pre_bit3", 32'(tr_tx[290]), 32'd0);
    cnt = 0;
    for (int n = 1; n <= 800; n++) if (tr_done[n]) cnt++;
    chk("rst_no_done", 32'(cnt), 32'd0);
    chk("rst_after_tx", 32'(tr_tx[700]), 32'd1);
    chk("rst_after_busy", 32'(tr_busy[700]), 32'd0);
    launch(0, 8'h81);
    capture(0, 700, 0);
    check_frame("f81", 16'h0081, 8, 640, 700);

    // tx_start toggling and din changing mid-frame must not disturb the frame.
    launch(0, 8'h3C);
    capture(0, 700, 1);
    check_frame("tog", 16'h003C, 8, 640, 700);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
